// File: rtl/jesd_tx_pkg.sv
// Shared constants and types for the JESD TX character-clock sequencer.
package jesd_tx_pkg;

    // 8b/10b control characters used on the lane
    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ code group sync
    localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ config data follows

    // Number of link configuration octets carried in ILAS multiframe 1
    localparam int CFG_OCTETS = 14;
    localparam int CFG_W      = 8 * CFG_OCTETS;

    typedef enum logic [1:0] {
        CGS  = 2'd0,
        ILAS = 2'd1,
        DATA = 2'd2
    } state_e;

endpackage

// File: rtl/tx_ila_sequencer_ilas_octet_gen.sv
// Combinational ILAS octet map: (multiframe, octet position, config) -> {octet, k}.
module ilas_octet_gen
    import jesd_tx_pkg::*;
#(
    parameter int FK    = 32,
    parameter int OCT_W = 10
) (
    input  logic [2:0]       mf_cnt_i,
    input  logic [OCT_W-1:0] oct_cnt_i,
    input  logic [CFG_W-1:0] cfg_i,
    output logic [7:0]       octet_o,
    output logic             k_o
);

    localparam logic [OCT_W-1:0] OCT_LAST = OCT_W'(FK - 1);

    logic [7:0] cfg_sel;
    logic       in_cfg;

    // Pick the config octet addressed by positions 2..15 of multiframe 1
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        cfg_sel = '0;
        in_cfg  = 1'b0;
        for (int n = 0; n < CFG_OCTETS; n++) begin
            if (oct_cnt_i == OCT_W'(n + 2)) begin
                cfg_sel = cfg_i[8*n +: 8];
                in_cfg  = 1'b1;
            end
        end
    end

    // Apply the multiframe octet map in priority order
    always_comb begin
        octet_o = 8'(oct_cnt_i);  // ramp filler
        k_o     = 1'b0;
        if (oct_cnt_i == '0) begin
            octet_o = K28_0;
            k_o     = 1'b1;
        end else if (oct_cnt_i == OCT_LAST) begin
            octet_o = K28_3;
            k_o     = 1'b1;
        end else if (mf_cnt_i == 3'd1 && oct_cnt_i == OCT_W'(1)) begin
            octet_o = K28_4;
            k_o     = 1'b1;
        end else if (mf_cnt_i == 3'd1 && in_cfg) begin
            octet_o = cfg_sel;
        end
    end

endmodule

// File: rtl/tx_ila_sequencer.sv
// CGS -> ILAS -> DATA sequencer feeding one octet per character clock to the link layer.
module tx_ila_sequencer
    import jesd_tx_pkg::*;
#(
    parameter int F      = 8,
    parameter int K      = 4,
    parameter int ILA_MF = 4,
    parameter int OCT_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sync_request,
    input  logic             i_lmfc_edge,
    input  logic [CFG_W-1:0] i_cfg,
    input  logic [7:0]       i_data,
    input  logic             i_k,
    input  logic             i_vld,
    output logic             o_ready,
    output logic [7:0]       o_data,
    output logic             o_k,
    output logic             o_vld,
    output logic [1:0]       o_state,
    output logic             o_align_err
);

    localparam int               FK       = F * K;
    localparam logic [OCT_W-1:0] OCT_LAST = OCT_W'(FK - 1);
    localparam logic [2:0]       MF_LAST  = 3'(ILA_MF - 1);

    state_e           state_q, state_d;
    logic [OCT_W-1:0] oct_q, oct_d;
    logic [2:0]       mf_q, mf_d;

    logic [7:0] data_q, data_d;
    logic       k_q, k_d;
    logic       vld_q, vld_d;
    logic       err_q, err_d;

    logic [7:0] ila_octet;
    logic       ila_k;

    // Counters describe the octet that goes out on the next edge, so the
    // generator is driven from the next-state values.
    ilas_octet_gen #(
        .FK    (FK),
        .OCT_W (OCT_W)
    ) u_octet_gen (
        .mf_cnt_i  (mf_d),
        .oct_cnt_i (oct_d),
        .cfg_i     (i_cfg),
        .octet_o   (ila_octet),
        .k_o       (ila_k)
    );

    // State and position counters
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= CGS;
            oct_q   <= '0;
            mf_q    <= '0;
        end else begin
            state_q <= state_d;
            oct_q   <= oct_d;
            mf_q    <= mf_d;
        end
    end

    // Next state and next counter values; counters stay cleared outside ILAS
    always_comb begin
        state_d = state_q;
        oct_d   = '0;
        mf_d    = '0;
        unique case (state_q)
            CGS: begin
                if (!i_sync_request && i_lmfc_edge) state_d = ILAS;
            end
            ILAS: begin
                if (i_sync_request) begin
                    state_d = CGS;
                end else if (oct_q == OCT_LAST) begin
                    if (mf_q == MF_LAST) state_d = DATA;
                    else                 mf_d    = mf_q + 3'd1;
                end else begin
                    oct_d = oct_q + OCT_W'(1);
                    mf_d  = mf_q;
                end
            end
            DATA: begin
                if (i_sync_request) state_d = CGS;
            end
            default: state_d = CGS;
        endcase
    end

    // Output octet selection for the state entered on the next edge
    always_comb begin
        data_d = K28_5;
        k_d    = 1'b1;
        vld_d  = 1'b1;
        err_d  = 1'b0;
        unique case (state_d)
            ILAS: begin
                data_d = ila_octet;
                k_d    = ila_k;
                // An LMFC edge must coincide with octet 0 of the next multiframe
                err_d  = (state_q == ILAS) && i_lmfc_edge && (oct_d != '0);
            end
            DATA: begin
                data_d = i_vld ? i_data : data_q;
                k_d    = i_k;
                vld_d  = i_vld;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= K28_5;
            k_q    <= 1'b1;
            vld_q  <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            k_q    <= k_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end

    assign o_data      = data_q;
    assign o_k         = k_q;
    assign o_vld       = vld_q;
    assign o_align_err = err_q;
    assign o_state     = state_q;
    assign o_ready     = (state_q == DATA);

endmodule

// File: tb/tb_tx_ila_sequencer.sv
// Scoreboard bench for tx_ila_sequencer: a behavioural model pushes the
// expected output for every driven cycle, popped and compared after the edge.
module tb_tx_ila_sequencer;

    localparam int F      = 8;
    localparam int K      = 4;
    localparam int ILA_MF = 4;
    localparam int OCT_W  = 10;
    localparam int FK     = F * K;
    localparam int TOTAL  = ILA_MF * FK;

    localparam int S_CGS  = 0;
    localparam int S_ILAS = 1;
    localparam int S_DATA = 2;

    typedef struct {
        logic [7:0] data;
        logic       k;
        logic       vld;
        logic       ready;
        logic       err;
        logic [1:0] state;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_sync_request = 1'b1;
    logic         i_lmfc_edge = 1'b0;
    logic [111:0] i_cfg = '0;
    logic [7:0]   i_data = '0;
    logic         i_k = 1'b0;
    logic         i_vld = 1'b0;
    logic         o_ready;
    logic [7:0]   o_data;
    logic         o_k;
    logic         o_vld;
    logic [1:0]   o_state;
    logic         o_align_err;

    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc   = 0;
    string phase = "init";

    // Reference model state: ILAS progress is a single linear position
    int         m_state = S_CGS;
    int         m_p     = 0;
    logic [7:0] m_data  = 8'hBC;

    exp_t sb[$];

    tx_ila_sequencer #(
        .F      (F),
        .K      (K),
        .ILA_MF (ILA_MF),
        .OCT_W  (OCT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_sync_request (i_sync_request),
        .i_lmfc_edge    (i_lmfc_edge),
        .i_cfg          (i_cfg),
        .i_data         (i_data),
        .i_k            (i_k),
        .i_vld          (i_vld),
        .o_ready        (o_ready),
        .o_data         (o_data),
        .o_k            (o_k),
        .o_vld          (o_vld),
        .o_state        (o_state),
        .o_align_err    (o_align_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", phase, tag, got, exp, cyc);
        end
    endtask

    function automatic logic auto_lmfc();
        return (cyc % FK) == 0;
    endfunction

    // Expected ILAS octet straight from the multiframe octet map
    function automatic void ila_ref(input int mf, input int oct,
                                    output logic [7:0] d, output logic kk);
        logic [31:0] oct_v;
        oct_v = 32'(oct);
        if (oct == 0)                              begin d = 8'h1C; kk = 1'b1; end
        else if (oct == FK - 1)                    begin d = 8'h7C; kk = 1'b1; end
        else if (mf == 1 && oct == 1)              begin d = 8'h9C; kk = 1'b1; end
        else if (mf == 1 && oct >= 2 && oct <= 15) begin d = i_cfg[(oct-2)*8 +: 8]; kk = 1'b0; end
        else                                       begin d = oct_v[7:0]; kk = 1'b0; end
    endfunction

    // Drive one cycle, predict the registered result, then compare after the edge
    task automatic step(input logic r, input logic s, input logic l,
                        input logic [7:0] d, input logic kk, input logic v);
        exp_t e;
        exp_t got;
        rst = r; i_sync_request = s; i_lmfc_edge = l;
        i_data = d; i_k = kk; i_vld = v;

        e.err = 1'b0;
        if (r) begin
            m_state = S_CGS;
        end else begin
            case (m_state)
                S_CGS:  if (!s && l) begin m_state = S_ILAS; m_p = 0; end
                S_ILAS: begin
                    if (s)                     m_state = S_CGS;
                    else if (m_p == TOTAL - 1) m_state = S_DATA;
                    else begin
                        m_p++;
                        e.err = l && ((m_p % FK) != 0);
                    end
                end
                default: if (s) m_state = S_CGS;
            endcase
        end

        case (m_state)
            S_ILAS: begin
                ila_ref(m_p / FK, m_p % FK, e.data, e.k);
                e.vld = 1'b1;
            end
            S_DATA: begin
                e.data = v ? d : m_data;
                e.k    = kk;
                e.vld  = v;
            end
            default: begin
                e.data = 8'hBC; e.k = 1'b1; e.vld = 1'b1;
            end
        endcase
        m_data  = e.data;
        e.state = 2'(m_state);
        e.ready = (m_state == S_DATA);
        sb.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        got = sb.pop_front();
        check("data",  32'(o_data),      32'(got.data));
        check("k",     32'(o_k),         32'(got.k));
        check("vld",   32'(o_vld),       32'(got.vld));
        check("state", 32'(o_state),     32'(got.state));
        check("ready", 32'(o_ready),     32'(got.ready));
        check("err",   32'(o_align_err), 32'(got.err));
    endtask

    task automatic step_rand(input logic s, input logic l);
        step(1'b0, s, l, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Advance with aligned LMFC and sync low until the model reaches a target
    task automatic run_until(input int st, input int pos, input int budget);
        int n = 0;
        while (!(m_state == st && (st != S_ILAS || m_p == pos)) && n < budget) begin
            step_rand(1'b0, auto_lmfc());
            n++;
        end
        if (n >= budget) check("timeout", 32'(n), 32'(budget - 1));
    endtask

    initial begin
        for (int n = 0; n < 14; n++) i_cfg[8*n +: 8] = 8'(8'h41 + 8'(n * 13));

        phase = "reset";
        repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        phase = "cgs_hold";
        for (int i = 0; i < 50; i++) step_rand(1'b1, auto_lmfc());

        phase = "ilas_full";
        run_until(S_DATA, 0, TOTAL + 2 * FK);

        phase = "data";
        step(1'b0, 1'b0, auto_lmfc(), 8'hA5, 1'b0, 1'b1);
        step(1'b0, 1'b0, auto_lmfc(), 8'h3C, 1'b0, 1'b0);
        step(1'b0, 1'b0, auto_lmfc(), 8'h5A, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step_rand(1'b0, auto_lmfc());

        phase = "resync_data";
        step_rand(1'b1, 1'b0);

        phase = "resync_ilas";
        run_until(S_ILAS, 39, 3 * FK);
        step_rand(1'b1, 1'b0);
        step_rand(1'b0, 1'b0);
        run_until(S_ILAS, 0, 2 * FK);
        for (int i = 0; i < 8; i++) step_rand(1'b0, auto_lmfc());

        phase = "sync_and_lmfc";
        step_rand(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step_rand(1'b1, 1'b1);

        phase = "align_err";
        run_until(S_ILAS, 9, 3 * FK);
        step_rand(1'b0, 1'b1);
        step_rand(1'b0, auto_lmfc());
        run_until(S_DATA, 0, TOTAL + FK);

        phase = "rst_mid_data";
        for (int i = 0; i < 5; i++) step_rand(1'b0, auto_lmfc());
        step_rand(1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step_rand(1'b1, auto_lmfc());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
